// File: rtl/spi_ram_cmd_engine.sv
// Command engine between the SPI word stream and a single-port RAM.
// Decodes opcode/address/length words and runs a WRITE or READ burst.
module spi_ram_cmd_engine #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int LEN_W       = 16,
  parameter int RAM_LATENCY = 1
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              abort,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_WDATA,
    S_RREQ,
    S_RWAIT,
    S_RSEND
  } state_t;

  typedef enum logic {
    M_WRITE,
    M_READ
  } mode_t;

  state_t            state_q;
  mode_t             mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [1:0]        lat_q;

  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]  rem_nxt;
  logic [LEN_W-1:0]  len_in;
  logic              last_word;

  assign addr_nxt  = addr_q + ADDR_W'(1);
  assign rem_nxt   = rem_q - LEN_W'(1);
  assign len_in    = rx_data[LEN_W-1:0];
  assign last_word = (rem_q == LEN_W'(1));
  assign busy      = (state_q != S_IDLE);

  // NOTE: every register here, including addr/rem, is cleared by the async
  // reset so a reset mid-burst drops any strobe in the very same instant.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= S_IDLE;
      mode_q    <= M_WRITE;
      addr_q    <= '0;
      rem_q     <= '0;
      lat_q     <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the defaults below make the
      // strobes single-cycle unless a branch re-asserts them.
      done    <= 1'b0;
      err     <= 1'b0;
      ram_req <= 1'b0;
      ram_we  <= 1'b0;

      if (abort && state_q != S_IDLE) begin
        // A write strobe registered last cycle has already gone out.
        state_q  <= S_IDLE;
        tx_valid <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (rx_valid && !abort) begin
              if (rx_data[7:0] == OP_WRITE) begin
                mode_q  <= M_WRITE;
                state_q <= S_ADDR;
              end else if (rx_data[7:0] == OP_READ) begin
                mode_q  <= M_READ;
                state_q <= S_ADDR;
              end else begin
                err <= 1'b1;
              end
            end
          end

          S_ADDR: begin
            if (rx_valid) begin
              addr_q  <= rx_data[ADDR_W-1:0];
              state_q <= S_LEN;
            end
          end

          S_LEN: begin
            if (rx_valid) begin
              rem_q <= len_in;
              if (len_in == '0) begin
                done    <= 1'b1;
                state_q <= S_IDLE;
              end else if (mode_q == M_WRITE) begin
                state_q <= S_WDATA;
              end else begin
                ram_req  <= 1'b1;
                ram_addr <= addr_q;
                state_q  <= S_RREQ;
              end
            end
          end

          S_WDATA: begin
            if (rx_valid) begin
              ram_req   <= 1'b1;
              ram_we    <= 1'b1;
              ram_addr  <= addr_q;
              ram_wdata <= rx_data;
              addr_q    <= addr_nxt;
              rem_q     <= rem_nxt;
              if (last_word) begin
                done    <= 1'b1;
                state_q <= S_IDLE;
              end
            end
          end

          S_RREQ: begin
            lat_q   <= LAT_LOAD;
            state_q <= S_RWAIT;
          end

          S_RWAIT: begin
            // Stay RAM_LATENCY cycles so ram_rdata is captured on the right edge.
            if (lat_q == 2'd0) begin
              tx_data  <= ram_rdata;
              tx_valid <= 1'b1;
              state_q  <= S_RSEND;
            end else begin
              lat_q <= lat_q - 2'd1;
            end
          end

          S_RSEND: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              addr_q   <= addr_nxt;
              rem_q    <= rem_nxt;
              if (last_word) begin
                done    <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                ram_req  <= 1'b1;
                ram_addr <= addr_nxt;
                state_q  <= S_RREQ;
              end
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_cmd_engine.sv
// Directed bench for spi_ram_cmd_engine with a 2-cycle-latency RAM model;
// outputs are logged 2 ns after each rising edge, inputs change on falling edges.
module tb_spi_ram_cmd_engine;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 16;
  localparam int LAT    = 2;

  logic              clk_sys = 1'b0;
  logic              rst_sys_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              abort = 1'b0;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready = 1'b0;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk_sys = ~clk_sys;

  spi_ram_cmd_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .RAM_LATENCY(LAT)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .abort(abort),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .err(err)
  );

  // RAM model: read data appears LAT cycles after the addressed cycle.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_pipe;
  always @(posedge clk_sys) begin
    if (ram_req && ram_we) mem[ram_addr] <= ram_wdata;
    rd_pipe   <= mem[ram_addr];
    ram_rdata <= rd_pipe;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Event log, indexed by cycle number (count of rising edges).
  int                cyc = 0;
  int                wr_cyc[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                rd_cyc[$];
  logic [ADDR_W-1:0] rd_addr[$];
  int                done_cyc[$];
  int                err_cyc[$];
  int                tx_cycles = 0;
  int                busy_cycles = 0;
  int                both_cycles = 0;

  initial forever begin
    @(posedge clk_sys);
    cyc++;
    #2;
    if (ram_req && ram_we) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(ram_addr); wr_data.push_back(ram_wdata);
    end
    if (ram_req && !ram_we) begin
      rd_cyc.push_back(cyc); rd_addr.push_back(ram_addr);
    end
    if (done) done_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
    if (tx_valid) tx_cycles++;
    if (busy) busy_cycles++;
    if (done && err) both_cycles++;
  end

  task automatic clear_log();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rd_cyc.delete(); rd_addr.delete();
    done_cyc.delete(); err_cyc.delete();
    tx_cycles = 0; busy_cycles = 0;
  endtask

  task automatic send(input logic [DATA_W-1:0] w, output int c);
    @(negedge clk_sys);
    c        = cyc;
    rx_valid = 1'b1;
    rx_data  = w;
  endtask

  task automatic quiet();
    @(negedge clk_sys);
    rx_valid = 1'b0;
    rx_data  = '0;
    abort    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_tx(input string tag, output int c, output logic [DATA_W-1:0] d);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (!tx_valid && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    c = cyc;
    d = tx_data;
    check({tag, "_arrived"}, tx_valid, 1);
  endtask

  initial begin
    int c, d_len, r, h, c_tx;
    int dw[3];
    logic [DATA_W-1:0] d_tx;

    // Reset values
    idle(2);
    check("rst_ctrl", {tx_valid, ram_req, ram_we, busy, done, err}, 6'b0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    rst_sys_n = 1'b1;
    idle(2);

    // WRITE burst of three words at 0x10
    clear_log();
    send(32'h01, c); send(32'h10, c); send(32'h3, c);
    send(32'hA, dw[0]); send(32'hB, dw[1]); send(32'hC, dw[2]);
    quiet(); idle(2);
    check("wr_count", wr_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr%0d_addr", i), wr_addr[i], 64'h10 + 64'(i));
      check($sformatf("wr%0d_data", i), wr_data[i], 64'hA + 64'(i));
      check($sformatf("wr%0d_cyc", i), wr_cyc[i], dw[i] + 1);
    end
    check("wr_done_count", done_cyc.size(), 1);
    check("wr_done_cyc", done_cyc[0], dw[2] + 1);
    check("wr_busy_after", busy, 0);

    // Preload 0x20/0x21 for the read tests
    send(32'h01, c); send(32'h20, c); send(32'h2, c);
    send(32'h11, c); send(32'h22, c);
    quiet(); idle(2);

    // READ of two words with a 5-cycle tx_ready stall
    clear_log();
    tx_ready = 1'b0;
    send(32'h02, c); send(32'h20, c); send(32'h2, d_len);
    quiet();
    r = d_len + 1;
    wait_tx("rd0", c_tx, d_tx);
    check("rd0_req_count", rd_cyc.size(), 1);
    check("rd0_req_cyc", rd_cyc[0], r);
    check("rd0_req_addr", rd_addr[0], 16'h20);
    check("rd0_tx_cyc", c_tx, r + 3);
    check("rd0_tx_data", d_tx, 32'h11);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, 32'h11);
      @(negedge clk_sys);
    end
    h = cyc;
    tx_ready = 1'b1;
    @(negedge clk_sys);
    check("hs0_valid_drop", tx_valid, 0);
    check("hs0_no_done", done_cyc.size(), 0);
    check("rd1_req_count", rd_cyc.size(), 2);
    check("rd1_req_cyc", rd_cyc[1], h + 1);
    check("rd1_req_addr", rd_addr[1], 16'h21);
    wait_tx("rd1", c_tx, d_tx);
    check("rd1_tx_cyc", c_tx, h + 4);
    check("rd1_tx_data", d_tx, 32'h22);
    idle(2);
    check("rd_done_count", done_cyc.size(), 1);
    check("rd_done_cyc", done_cyc[0], h + 5);
    check("rd_busy_after", busy, 0);
    check("rd_no_writes", wr_cyc.size(), 0);

    // Unknown opcode
    clear_log();
    send(32'h7F, c);
    quiet(); idle(3);
    check("err_count", err_cyc.size(), 1);
    check("err_cyc", err_cyc[0], c + 1);
    check("err_busy", busy_cycles, 0);
    check("err_no_ram", wr_cyc.size() + rd_cyc.size(), 0);

    // Zero-length WRITE
    clear_log();
    send(32'h01, c); send(32'h100, c); send(32'h0, d_len);
    quiet(); idle(3);
    check("zlen_done_count", done_cyc.size(), 1);
    check("zlen_done_cyc", done_cyc[0], d_len + 1);
    check("zlen_no_ram", wr_cyc.size() + rd_cyc.size(), 0);
    check("zlen_no_err", err_cyc.size(), 0);

    // Address wrap; opcode upper bits must be ignored
    clear_log();
    send(32'hABCD_0001, c); send(32'hFFFF, c); send(32'h2, c);
    send(32'h55, c); send(32'h66, c);
    quiet(); idle(2);
    check("wrap_count", wr_cyc.size(), 2);
    check("wrap_addr0", wr_addr[0], 16'hFFFF);
    check("wrap_data0", wr_data[0], 32'h55);
    check("wrap_addr1", wr_addr[1], 16'h0000);
    check("wrap_data1", wr_data[1], 32'h66);
    check("wrap_done", done_cyc.size(), 1);

    // Abort while waiting on the RAM read
    clear_log();
    tx_ready = 1'b1;
    send(32'h02, c); send(32'h20, c); send(32'h1, d_len);
    quiet();
    r = d_len + 1;
    @(negedge clk_sys);
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    check("abrd_busy", busy, 0);
    check("abrd_cyc", cyc, r + 2);
    idle(6);
    check("abrd_no_tx", tx_cycles, 0);
    check("abrd_no_done", done_cyc.size(), 0);
    check("abrd_one_req", rd_cyc.size(), 1);
    tx_ready = 1'b0;

    // Abort together with a data word, then a fresh command
    clear_log();
    send(32'h01, c); send(32'h40, c); send(32'h3, c); send(32'hAA, dw[0]);
    @(negedge clk_sys);
    rx_valid = 1'b1; rx_data = 32'hBB; abort = 1'b1;
    quiet();
    check("abwr_busy", busy, 0);
    send(32'h01, c); send(32'h50, c); send(32'h1, c); send(32'hCC, dw[1]);
    quiet(); idle(2);
    check("abwr_count", wr_cyc.size(), 2);
    check("abwr_addr0", wr_addr[0], 16'h40);
    check("abwr_data0", wr_data[0], 32'hAA);
    check("abwr_cyc0", wr_cyc[0], dw[0] + 1);
    check("abwr_addr1", wr_addr[1], 16'h50);
    check("abwr_data1", wr_data[1], 32'hCC);
    check("abwr_done_count", done_cyc.size(), 1);
    check("abwr_done_cyc", done_cyc[0], dw[1] + 1);

    // Reset during RSEND, then a fresh WRITE
    clear_log();
    send(32'h02, c); send(32'h20, c); send(32'h2, c);
    quiet();
    wait_tx("rst_pre", c_tx, d_tx);
    check("rst_pre_data", d_tx, 32'h11);
    #1 rst_sys_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {tx_valid, busy, ram_req}, 3'b0);
    idle(2);
    rst_sys_n = 1'b1;
    idle(1);
    clear_log();
    send(32'h01, c); send(32'h60, c); send(32'h1, c); send(32'h77, dw[0]);
    quiet(); idle(2);
    check("post_rst_count", wr_cyc.size(), 1);
    check("post_rst_addr", wr_addr[0], 16'h60);
    check("post_rst_data", wr_data[0], 32'h77);
    check("post_rst_cyc", wr_cyc[0], dw[0] + 1);
    check("post_rst_done", done_cyc.size(), 1);
    check("post_rst_busy", busy, 0);

    check("done_err_overlap", both_cycles, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_ram_cmd_engine.md
Name: spi_ram_cmd_engine

Overview:
- Command engine between the SPI word deserializer/serializer and a single-port on-chip RAM.
- Decodes a command word, then an address word and a length word, and executes a burst:
  - WRITE: one RAM write per received data word.
  - READ: one RAM read per returned word, sent through a ready/valid stream.
- Generalises the single-command write path to parametrised widths, burst length, RAM read latency, read mode, abort and error reporting.

Parameters:
DATA_W, 32, SPI word and RAM data width (>= 8)
ADDR_W, 16, RAM word-address width (<= DATA_W)
LEN_W, 16, burst length field width (<= DATA_W)
RAM_LATENCY, 1, RAM read latency in cycles (1..4)

Ports:
clk_sys  in  1  system clock
rst_sys_n  in  1  reset, asynchronous, active-low
rx_valid  in  1  one-cycle pulse: rx_data holds a received SPI word
rx_data  in  DATA_W  received word
abort  in  1  packet end / CS deassert; terminates current command
tx_valid  out  1  read word available for serializer
tx_data  out  DATA_W  read word
tx_ready  in  1  serializer accepts tx_data
ram_req  out  1  RAM access strobe, one cycle per access
ram_we  out  1  1 = write, 0 = read (meaningful only with ram_req)
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on normal command completion
err  out  1  one-cycle pulse on unknown opcode

Behaviour:
Clocking, reset and decode:
- Clock clk_sys; reset rst_sys_n, asynchronous, active-low.
- In reset: state IDLE; all outputs 0; internal addr/remaining counters 0.
- Opcode = rx_data[7:0]: 0x01 WRITE, 0x02 READ. Upper bits are ignored.

FSM states: IDLE, ADDR, LEN, WDATA, RREQ, RWAIT, RSEND.
- IDLE:
  - rx_valid with WRITE or READ -> ADDR; latch mode.
  - Other opcode -> err pulse next cycle, stay IDLE.
- ADDR: rx_valid -> addr_q <= rx_data[ADDR_W-1:0]; -> LEN.
- LEN: rx_valid -> rem <= rx_data[LEN_W-1:0].
  - rem = 0 -> done pulse next cycle, -> IDLE; no RAM access.
  - Otherwise WRITE -> WDATA, READ -> RREQ.
- WDATA: rx_valid in cycle N -> in cycle N+1: ram_req=1, ram_we=1, ram_addr=addr_q, ram_wdata=rx_data(N).
  - Then addr_q++ and rem--.
  - Last word: done=1 in the same cycle N+1; state IDLE from N+1.
  - rx_valid on consecutive cycles is supported (one write per cycle).
- RREQ: ram_req=1, ram_we=0, ram_addr=addr_q for exactly one cycle R; -> RWAIT.
- RWAIT: ram_rdata is sampled at the edge ending cycle R+RAM_LATENCY.
  - tx_data is loaded from that sample; tx_valid=1 from cycle R+RAM_LATENCY+1; -> RSEND.
- RSEND: hold tx_valid and tx_data stable until tx_valid & tx_ready in cycle H.
  - tx_valid=0 in H+1; addr_q++ and rem--.
  - rem was 1 -> done pulse in H+1, -> IDLE; otherwise -> RREQ in H+1.
- rx_valid during RREQ/RWAIT/RSEND: ignored (full-duplex dummy words).

Arithmetic:
- addr_q increments modulo 2^ADDR_W: 0xFFFF wraps to 0x0000 at default width.
- rem is unsigned LEN_W bits; maximum burst 2^LEN_W-1.

Abort:
- abort in any non-IDLE state -> IDLE next cycle. tx_valid, ram_req and done are all 0 in that cycle.
- An in-flight read result is discarded. No further RAM accesses occur.
- A write whose ram_req is already scheduled (rx_valid accepted the previous cycle) still completes.
- abort has priority over rx_valid in the same cycle; that rx_valid is dropped.
- abort in IDLE: no effect (a simultaneous rx_valid is dropped).

Other:
- Reset mid-operation: immediate return to reset values; no partial RAM strobe.
- done and err are never asserted in the same cycle.

Test Plan:
- WRITE burst: rx words 0x01, 0x0010, 0x0003, 0xA, 0xB, 0xC on consecutive cycles -> writes (0x10,0xA), (0x11,0xB), (0x12,0xC), each one cycle after its rx_valid; done with the third write; busy low after.
- READ with stall: RAM preloaded 0x20=0x11, 0x21=0x22; RAM_LATENCY=2; cmd 0x02, 0x20, 2; tx_ready low 5 cycles -> ram_req at R; tx_valid at R+3 holding 0x11 stable through the stall; then 0x22; done after the second handshake.
- Errors/zero length: opcode 0x7F -> err pulse, busy stays 0, no ram_req. WRITE with length 0 -> done pulse, no ram_req.
- Address wrap: WRITE addr 0xFFFF, len 2 -> writes at 0xFFFF then 0x0000.
- Abort: abort during READ RWAIT -> no tx_valid, no done, IDLE next cycle. abort with rx_valid in WDATA -> that word never written; a new command is accepted afterwards.
- Reset mid-burst: rst_sys_n low during RSEND -> tx_valid, busy and ram_req 0 immediately; after release a fresh WRITE completes normally.
